// File: rtl/bp_pkg.sv
// Shared types for the branch pattern history table.
// Counter encoding is the conventional 2-bit bimodal scheme.
package bp_pkg;

  typedef enum logic [1:0] {
    S_SNT = 2'b00,
    S_WNT = 2'b01,
    S_WT  = 2'b10,
    S_ST  = 2'b11
  } ctr_e;

  // Value every entry holds after the init sweep (weakly not-taken).
  localparam ctr_e S_INIT = S_WNT;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } fsm_e;

endpackage

// File: rtl/bp_sat_next.sv
// Next value of a 2-bit saturating counter given the resolved branch outcome.
module bp_sat_next
  import bp_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] nxt
);

  // Step toward strong-taken or strong-not-taken, holding at either end.
  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != S_ST) nxt = cur + 2'd1;
    end else begin
      if (cur != S_SNT) nxt = cur - 2'd1;
    end
  end

endmodule

// File: rtl/bp_pht.sv
// Pattern history table: 2^IDX_W two-bit counters, combinational lookup for
// fetch, one resolved-branch update per cycle from execute.
// Build option: define BP_GSHARE_EN to XOR the PC index with a global history
// register (HIST_W must equal IDX_W); otherwise indexing is PC-only.
module bp_pht
  import bp_pkg::*;
#(
  parameter int IDX_W  = 6,
  parameter int PC_LSB = 2,
  parameter int HIST_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pred_pc,
  output logic              pred_taken,
  output logic [HIST_W-1:0] pred_ghr,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic [HIST_W-1:0] upd_ghr,
  input  logic              upd_taken,
  output logic              ready
);

  localparam int ENTRIES = 1 << IDX_W;

  fsm_e             state;
  logic [IDX_W-1:0] init_idx;
  logic             ready_q;
  logic [1:0]       pht [ENTRIES];

  logic [IDX_W-1:0] pidx;
  logic [IDX_W-1:0] uidx;
  logic [1:0]       upd_cur;
  logic [1:0]       upd_nxt;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       wr_data;

  // Only the index slice of each PC is meaningful; the rest is consumed here.
  logic             unused_bits;

`ifdef BP_GSHARE_EN
  logic [HIST_W-1:0] ghr;

  // Non-speculative history: shifts on the same edge as the table write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ghr <= '0;
    end else if (state == ST_READY && upd_valid) begin
      ghr <= {ghr[HIST_W-2:0], upd_taken};
    end
  end

  assign pidx        = pred_pc[PC_LSB+IDX_W-1:PC_LSB] ^ ghr;
  assign uidx        = upd_pc[PC_LSB+IDX_W-1:PC_LSB] ^ upd_ghr;
  assign pred_ghr    = ghr;
  assign unused_bits = ^{pred_pc, upd_pc};
`else
  assign pidx        = pred_pc[PC_LSB+IDX_W-1:PC_LSB];
  assign uidx        = upd_pc[PC_LSB+IDX_W-1:PC_LSB];
  assign pred_ghr    = '0;
  assign unused_bits = ^{pred_pc, upd_pc, upd_ghr};
`endif

  // Read-modify-write path for execute updates.
  assign upd_cur = pht[uidx];

  bp_sat_next u_sat_next (
    .cur   (upd_cur),
    .taken (upd_taken),
    .nxt   (upd_nxt)
  );

  // Init/ready sequencing: sweep every entry once, then serve predictions.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_INIT;
      init_idx <= '0;
      ready_q  <= 1'b0;
    end else begin
      unique case (state)
        ST_INIT: begin
          init_idx <= init_idx + 1'b1;
          if (init_idx == '1) begin
            state   <= ST_READY;
            ready_q <= 1'b1;
          end
        end
        ST_READY: begin
          state   <= ST_READY;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= ST_INIT;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Single write port: the init sweep owns it until ready; updates during
  // INIT are dropped.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = init_idx;
    wr_data = S_INIT;
    if (state == ST_INIT) begin
      wr_en = 1'b1;
    end else if (upd_valid) begin
      wr_en   = 1'b1;
      wr_idx  = uidx;
      wr_data = upd_nxt;
    end
  end

  // Table storage; contents are defined by the sweep, not by reset.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      pht[wr_idx] <= wr_data;
    end
  end

  assign pred_taken = ready_q & pht[pidx][1];
  assign ready      = ready_q;

endmodule

// File: tb/tb_bp_pht.sv
// Self-checking bench for bp_pht against a behavioural table model.
// Define BP_GSHARE_EN for both bench and RTL to exercise the gshare build.
module tb_bp_pht;

  localparam int IDX_W   = 6;
  localparam int PC_LSB  = 2;
  localparam int HIST_W  = 6;
  localparam int ENTRIES = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       pred_pc;
  logic              pred_taken;
  logic [HIST_W-1:0] pred_ghr;
  logic              upd_valid;
  logic [31:0]       upd_pc;
  logic [HIST_W-1:0] upd_ghr;
  logic              upd_taken;
  logic              ready;

  always #5 clk = ~clk;

  bp_pht #(.IDX_W(IDX_W), .PC_LSB(PC_LSB), .HIST_W(HIST_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .pred_pc    (pred_pc),
    .pred_taken (pred_taken),
    .pred_ghr   (pred_ghr),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_ghr    (upd_ghr),
    .upd_taken  (upd_taken),
    .ready      (ready)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: counters as integers 0..3, history as an integer.
  int unsigned mdl_ctr [ENTRIES];
  int unsigned mdl_ghr;
  bit          mdl_ready;
  int unsigned mdl_cnt;

  function automatic int unsigned pc_slot(logic [31:0] pc);
    return (pc >> PC_LSB) % ENTRIES;
  endfunction

  function automatic int unsigned pred_slot(logic [31:0] pc);
`ifdef BP_GSHARE_EN
    return pc_slot(pc) ^ mdl_ghr;
`else
    return pc_slot(pc);
`endif
  endfunction

  function automatic int unsigned upd_slot(logic [31:0] pc, int unsigned g);
`ifdef BP_GSHARE_EN
    return pc_slot(pc) ^ g;
`else
    return pc_slot(pc) + 0 * g;
`endif
  endfunction

  function automatic bit exp_pred(logic [31:0] pc);
    return mdl_ready && (mdl_ctr[pred_slot(pc)] >= 2);
  endfunction

  function automatic logic [HIST_W-1:0] exp_ghr();
    return HIST_W'(mdl_ghr);
  endfunction

  // PC for a table slot with random don't-care bits above and below the index.
  function automatic logic [31:0] pc_of(int unsigned slot);
    return ($urandom & 32'hFFFF_FF00) | (32'(slot % ENTRIES) << PC_LSB) | ($urandom & 32'h3);
  endfunction

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    bit          r;
    bit          u;
    bit          t;
    int unsigned s;
    r = rst;
    u = upd_valid;
    t = upd_taken;
    s = upd_slot(upd_pc, upd_ghr);
    @(posedge clk);
    #1;
    if (!r) begin
      mdl_ready = 0;
      mdl_cnt   = 0;
      mdl_ghr   = 0;
    end else if (!mdl_ready) begin
      mdl_cnt++;
      if (mdl_cnt == ENTRIES) begin
        mdl_ready = 1;
        foreach (mdl_ctr[i]) mdl_ctr[i] = 1;
      end
    end else if (u) begin
      if (t) mdl_ctr[s] = (mdl_ctr[s] == 3) ? 3 : mdl_ctr[s] + 1;
      else   mdl_ctr[s] = (mdl_ctr[s] == 0) ? 0 : mdl_ctr[s] - 1;
`ifdef BP_GSHARE_EN
      mdl_ghr = ((mdl_ghr << 1) | int'(t)) % ENTRIES;
`endif
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_ghr = '0; upd_taken = 1'b0;
    pred_pc = 32'h0;
    repeat (3) tick();
    #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b exp 0", ready); end
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred got %0b exp 0", pred_taken); end
    checks++;
    if (pred_ghr !== '0) begin errors++; $display("FAIL reset_ghr got %0h exp 0", pred_ghr); end
    rst = 1'b1;
    for (int i = 0; i < ENTRIES; i++) begin
      pred_pc = $urandom;
      #1;
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL init_ready_low cyc %0d got %0b exp 0", i, ready); end
      checks++;
      if (pred_taken !== 1'b0) begin errors++; $display("FAIL init_pred cyc %0d got %0b exp 0", i, pred_taken); end
      tick();
    end
    #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL ready_rise got %0b exp 1", ready); end
    for (int e = 0; e < ENTRIES; e++) begin
      pred_pc = pc_of(e);
      #1;
      checks++;
      if (pred_taken !== 1'b0) begin errors++; $display("FAIL init_entry %0d got %0b exp 0", e, pred_taken); end
    end
  endtask

  task automatic test_train();
    bit exp_seq [6];
    exp_seq = '{0, 1, 1, 1, 1, 1};
    upd_valid = 1'b0;
    pred_pc   = 32'h40;
    #1;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (pred_taken !== exp_pred(pred_pc))
        begin errors++; $display("FAIL train_pred step %0d got %0b exp %0b", k, pred_taken, exp_pred(pred_pc)); end
`ifndef BP_GSHARE_EN
      checks++;
      if (pred_taken !== exp_seq[k])
        begin errors++; $display("FAIL train_seq step %0d got %0b exp %0b", k, pred_taken, exp_seq[k]); end
`endif
      if (k < 5) begin
        upd_valid = 1'b1;
        upd_pc    = 32'h40;
        upd_ghr   = exp_ghr();
        upd_taken = (k < 4);
        tick();
        upd_valid = 1'b0;
        #1;
      end
    end
  endtask

  task automatic test_same_cycle();
    bit e0;
    upd_valid = 1'b1;
    upd_pc    = 32'h80;
    upd_ghr   = exp_ghr();
    upd_taken = 1'b1;
    pred_pc   = 32'h80;
    #1;
    e0 = exp_pred(pred_pc);
    checks++;
    if (pred_taken !== e0) begin errors++; $display("FAIL same_cycle_pre got %0b exp %0b", pred_taken, e0); end
    tick();
    upd_valid = 1'b0;
    #1;
    checks++;
    if (pred_taken !== exp_pred(pred_pc))
      begin errors++; $display("FAIL same_cycle_post got %0b exp %0b", pred_taken, exp_pred(pred_pc)); end
  endtask

  task automatic test_back_to_back();
    int unsigned slot;
    slot = $urandom_range(0, ENTRIES - 1);
    for (int k = 0; k < 16; k++) begin
      upd_valid = 1'b1;
      upd_pc    = pc_of(slot);
      upd_ghr   = exp_ghr();
      upd_taken = (k < 5) ? 1'b0 : ((k < 11) ? 1'b1 : 1'($urandom));
      pred_pc   = pc_of(slot);
      #1;
      checks++;
      if (pred_taken !== exp_pred(pred_pc))
        begin errors++; $display("FAIL b2b_pred step %0d got %0b exp %0b", k, pred_taken, exp_pred(pred_pc)); end
      tick();
    end
    upd_valid = 1'b0;
    pred_pc   = pc_of(slot);
    #1;
    checks++;
    if (pred_taken !== exp_pred(pred_pc))
      begin errors++; $display("FAIL b2b_final got %0b exp %0b", pred_taken, exp_pred(pred_pc)); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      pred_pc   = pc_of($urandom_range(0, 15));
      upd_valid = ($urandom_range(0, 3) != 0);
      upd_pc    = pc_of($urandom_range(0, 15));
      upd_ghr   = ($urandom_range(0, 1) != 0) ? exp_ghr() : HIST_W'($urandom);
      upd_taken = 1'($urandom);
      #1;
      checks++;
      if (pred_taken !== exp_pred(pred_pc))
        begin errors++; $display("FAIL rand_pred cyc %0d got %0b exp %0b", k, pred_taken, exp_pred(pred_pc)); end
      checks++;
      if (pred_ghr !== exp_ghr())
        begin errors++; $display("FAIL rand_ghr cyc %0d got %0h exp %0h", k, pred_ghr, exp_ghr()); end
      tick();
    end
    upd_valid = 1'b0;
  endtask

  task automatic test_init_updates();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    for (int i = 0; i < ENTRIES; i++) begin
      upd_valid = 1'b1;
      upd_pc    = pc_of($urandom_range(0, ENTRIES - 1));
      upd_ghr   = HIST_W'($urandom);
      upd_taken = ($urandom_range(0, 3) != 0);
      tick();
    end
    upd_valid = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL initupd_ready got %0b exp 1", ready); end
    checks++;
    if (pred_ghr !== '0) begin errors++; $display("FAIL initupd_ghr got %0h exp 0", pred_ghr); end
    for (int e = 0; e < ENTRIES; e++) begin
      pred_pc = pc_of(e);
      #1;
      checks++;
      if (pred_taken !== 1'b0) begin errors++; $display("FAIL initupd_entry %0d got %0b exp 0", e, pred_taken); end
    end
    // One taken update per entry: a weak-NT entry must flip to predicting taken.
    for (int e = 0; e < ENTRIES; e++) begin
      upd_valid = 1'b1;
      upd_pc    = pc_of(e);
      upd_ghr   = exp_ghr();
      upd_taken = 1'b1;
      tick();
      upd_valid = 1'b0;
      pred_pc   = pc_of(e);
      #1;
      checks++;
      if (pred_taken !== exp_pred(pred_pc))
        begin errors++; $display("FAIL initupd_bump %0d got %0b exp %0b", e, pred_taken, exp_pred(pred_pc)); end
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b0; upd_valid = 1'b0;
    tick();
    rst = 1'b1;
    repeat (30) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < ENTRIES; i++) begin
      #1;
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL mid_ready_low cyc %0d got %0b exp 0", i, ready); end
      tick();
    end
    #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL mid_ready_rise got %0b exp 1", ready); end
    for (int k = 0; k < 40; k++) begin
      upd_valid = 1'b1;
      upd_pc    = pc_of($urandom_range(0, 7));
      upd_ghr   = exp_ghr();
      upd_taken = 1'b1;
      tick();
    end
    upd_valid = 1'b0;
    rst = 1'b0;
    tick();
    #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL rdy_reset_ready got %0b exp 0", ready); end
    rst = 1'b1;
    repeat (ENTRIES) tick();
    #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL rdy_reset_rise got %0b exp 1", ready); end
    checks++;
    if (pred_ghr !== '0) begin errors++; $display("FAIL rdy_reset_ghr got %0h exp 0", pred_ghr); end
    for (int e = 0; e < ENTRIES; e++) begin
      pred_pc = pc_of(e);
      #1;
      checks++;
      if (pred_taken !== 1'b0) begin errors++; $display("FAIL rdy_reset_entry %0d got %0b exp 0", e, pred_taken); end
    end
  endtask

  task automatic test_ghr();
    logic [HIST_W-1:0] want_ghr;
    bit                outc [3];
    outc = '{1, 1, 0};
    rst = 1'b0; upd_valid = 1'b0;
    tick();
    rst = 1'b1;
    repeat (ENTRIES) tick();
    for (int k = 0; k < 3; k++) begin
      upd_valid = 1'b1;
      upd_pc    = 32'h100;
      upd_ghr   = exp_ghr();
      upd_taken = outc[k];
      tick();
    end
    upd_valid = 1'b0;
    #1;
`ifdef BP_GSHARE_EN
    want_ghr = 6'b000110;
`else
    want_ghr = '0;
`endif
    checks++;
    if (pred_ghr !== want_ghr) begin errors++; $display("FAIL ghr_ttn got %0h exp %0h", pred_ghr, want_ghr); end
    // Update with upd_ghr=0x06 at pc 0x40: gshare hits entry 0x16, else 0x10.
    upd_valid = 1'b1;
    upd_pc    = 32'h40;
    upd_ghr   = 6'h06;
    upd_taken = 1'b1;
    tick();
    upd_valid = 1'b0;
`ifdef BP_GSHARE_EN
    pred_pc = 32'h6C;   // 0x1B ^ ghr 0x0D = entry 0x16
`else
    pred_pc = 32'h40;   // entry 0x10
`endif
    #1;
    checks++;
    if (pred_taken !== 1'b1) begin errors++; $display("FAIL ghr_hit got %0b exp 1", pred_taken); end
    checks++;
    if (pred_taken !== exp_pred(pred_pc))
      begin errors++; $display("FAIL ghr_hit_model got %0b exp %0b", pred_taken, exp_pred(pred_pc)); end
`ifdef BP_GSHARE_EN
    pred_pc = 32'h74;   // 0x1D ^ 0x0D = entry 0x10, untouched
`else
    pred_pc = 32'h58;   // entry 0x16, untouched
`endif
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL ghr_miss got %0b exp 0", pred_taken); end
  endtask

  initial begin
    mdl_ready = 0; mdl_cnt = 0; mdl_ghr = 0;
    foreach (mdl_ctr[i]) mdl_ctr[i] = 0;
    test_reset();
    test_train();
    test_same_cycle();
    test_back_to_back();
    test_random();
    test_init_updates();
    test_reset_mid();
    test_ghr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
